// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an internal baud divider and a one-entry holding
// register so the producer can queue the next byte while a frame is on the line.
//
// Frame: start bit (0), 8 data bits LSB first, stop bit (1); every bit lasts
// CLKS_PER_BIT cycles of internal_clk. A byte accepted while a frame is running
// waits in the holding register and is launched straight after the current stop
// bit, so consecutive frames have no idle gap.
//
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between the
// data bits and the stop bit, giving an 11-bit frame.

module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       internal_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    // A one-cycle bit period would leave no room for the counter to wrap.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end

    localparam int unsigned    CntW   = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic accept;
    logic bit_end;
    logic load_direct;

    assign o_ready = ~hold_full_q;
    assign o_busy  = (state_q != StIdle);
    assign accept  = i_valid & ~hold_full_q;
    assign bit_end = (cnt_q == CntMax);

    // State register; reset returns the line to idle-high and drops any queued byte.
    always_ff @(posedge internal_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Frame sequencing, baud timing, byte loading and the serial line level.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        load_direct = 1'b0;
        o_done      = 1'b0;
        o_tx        = 1'b1;

        // The baud counter free-runs through a frame and wraps on each bit boundary.
        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                o_tx = 1'b1;
                if (accept) begin
                    load_direct = 1'b1;
                end
            end

            StStart: begin
                o_tx = 1'b0;
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end

            StData: begin
                o_tx = shift_q[0];
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                o_tx = parity_q;
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif

            StStop: begin
                o_tx = 1'b1;
                if (bit_end) begin
                    o_done = 1'b1;
                    if (hold_full_q) begin
                        // Queued byte follows immediately with no idle gap.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = StStart;
`ifdef UART_TX_PARITY_EN
                        parity_d    = ^hold_q;
`endif
                    end else if (accept) begin
                        load_direct = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A byte accepted with no frame to follow goes straight into the shifter;
        // one accepted mid-frame waits in the holding register.
        if (load_direct) begin
            shift_d = i_data;
            state_d = StStart;
            cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^i_data;
`endif
        end else if (accept) begin
            hold_d      = i_data;
            hold_full_d = 1'b1;
        end
    end

    // A queued byte can only exist while a frame is on the line.
    hold_only_when_busy: assert property (
        @(posedge internal_clk) disable iff (i_rst) hold_full_q |-> o_busy
    );

    // The end-of-frame pulse belongs to the stop bit.
    done_only_in_stop: assert property (
        @(posedge internal_clk) disable iff (i_rst) o_done |-> (state_q == StStop)
    );

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model predicts the
// line, busy, done and ready behaviour per cycle, and an independent mid-bit
// sampling receiver decodes the captured line back into bytes.
module tb_uart_tx;

    localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBits = 11;
`else
    localparam int unsigned NBits = 10;
`endif
    localparam int unsigned FrameLen = NBits * Cpb;

    logic       internal_clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    uart_tx #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .internal_clk(internal_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_tx        (o_tx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial internal_clk = 1'b0;
    always #5 internal_clk = ~internal_clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] stim_q[$];
    int         gap_q[$];
    int         gap_max;
    logic       got_tx[$], exp_tx[$], got_busy[$], exp_busy[$];
    logic       got_done[$], exp_done[$], got_ready[$], exp_ready[$];
    int         done_at[$];
    logic [7:0] rx_q[$];
    int         rx_bad;
    int         tx_err, busy_err, done_err, ready_err, first_err;
    bit         timed_out;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal finish");
        $fatal(1, "watchdog");
    end

    // Level of bit k of the frame carrying byte b (0 = start bit).
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(k - 1)];
        if (NBits == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic int next_gap(input int k);
        if (k < gap_q.size()) return gap_q[k];
        if (gap_max == 0) return 0;
        return int'($urandom_range(gap_max, 0));
    endfunction

    task automatic tick();
        @(posedge internal_clk);
        #1;
    endtask

    // Drive stim_q (gap before each byte from gap_q or random), predict every
    // sample from the frame model, capture the DUT, then decode the line.
    task automatic run_traffic(input int tail);
        int         n = 0;
        int         idx = 0;
        int         gap;
        int         idle_left = tail;
        bit         active = 0;
        int         fstart = 0;
        logic [7:0] cur = 8'h00;
        logic [7:0] hold[$];
        bit         drive;
        bit         acc;
        int         s;
        logic [7:0] b;

        got_tx.delete();   exp_tx.delete();   got_busy.delete();  exp_busy.delete();
        got_done.delete(); exp_done.delete(); got_ready.delete(); exp_ready.delete();
        done_at.delete();  rx_q.delete();
        timed_out = 0;
        gap = next_gap(0);

        forever begin
            if (idx >= stim_q.size() && !active) begin
                if (idle_left == 0) break;
                idle_left--;
            end
            if (n > 20000) begin
                timed_out = 1;
                break;
            end
            drive   = (idx < stim_q.size()) && (gap == 0);
            i_valid = drive;
            i_data  = drive ? stim_q[idx] : 8'($urandom);
            acc     = drive && (hold.size() == 0);
            tick();
            n++;
            if (active && (fstart + int'(FrameLen) == n)) begin
                if (hold.size() != 0) begin
                    cur = hold.pop_front();
                    fstart = n;
                end else if (acc) begin
                    cur = i_data;
                    fstart = n;
                end else begin
                    active = 0;
                end
            end else if (!active) begin
                if (acc) begin
                    cur = i_data;
                    fstart = n;
                    active = 1;
                end
            end else if (acc) begin
                hold.push_back(i_data);
            end

            exp_tx.push_back(active ? frame_bit(cur, int'(n - fstart) / int'(Cpb)) : 1'b1);
            exp_busy.push_back(active);
            exp_done.push_back(active && (n == fstart + int'(FrameLen) - 1));
            exp_ready.push_back(hold.size() == 0);
            got_tx.push_back(o_tx);
            got_busy.push_back(o_busy);
            got_done.push_back(o_done);
            got_ready.push_back(o_ready);
            if (o_done === 1'b1) done_at.push_back(n);

            if (acc) begin
                idx++;
                gap = next_gap(idx);
            end else if (!drive && gap > 0) begin
                gap--;
            end
        end
        i_valid = 1'b0;

        tx_err = 0; busy_err = 0; done_err = 0; ready_err = 0; first_err = -1;
        for (int i = 0; i < got_tx.size(); i++) begin
            if (got_tx[i] !== exp_tx[i]) tx_err++;
            if (got_busy[i] !== exp_busy[i]) busy_err++;
            if (got_done[i] !== exp_done[i]) done_err++;
            if (got_ready[i] !== exp_ready[i]) ready_err++;
            if (first_err < 0 && (got_tx[i] !== exp_tx[i] || got_busy[i] !== exp_busy[i] ||
                                  got_done[i] !== exp_done[i] || got_ready[i] !== exp_ready[i]))
                first_err = i + 1;
        end

        // Independent receiver: find a falling edge, sample each bit mid-period.
        rx_bad = 0;
        s = 0;
        while (s < got_tx.size()) begin
            if (got_tx[s] === 1'b0) begin
                if (s + int'(FrameLen) > got_tx.size()) begin
                    rx_bad++;
                    break;
                end
                b = 8'h00;
                for (int k = 0; k < 8; k++) b[3'(k)] = got_tx[s + (k + 1) * Cpb + Cpb / 2];
                if (got_tx[s + Cpb / 2] !== 1'b0) rx_bad++;
                if (got_tx[s + (NBits - 1) * Cpb + Cpb / 2] !== 1'b1) rx_bad++;
                if (NBits == 11 && got_tx[s + 9 * Cpb + Cpb / 2] !== ^b) rx_bad++;
                rx_q.push_back(b);
                s += int'(FrameLen);
            end else begin
                s++;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_valid = 1'b1;
        i_data = 8'hA7;
        tick();
        tests++;
        if (o_tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b, required 1", o_tx); end
        tests++;
        if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", o_ready); end
        tests++;
        if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
        tests++;
        if (o_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", o_done); end
        i_valid = 1'b0;
        i_rst = 1'b0;
        repeat (3) tick();
        tests++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: tx=%b busy=%b, required tx=1 busy=0", o_tx, o_busy);
        end
    endtask

    task automatic test_single_frame();
        int pat_err = 0;
        int busy_cnt = 0;
        stim_q = '{8'h55};
        gap_q = '{0};
        gap_max = 0;
        run_traffic(4);
        tests++;
        if (timed_out !== 1'b0) begin fails++; $display("FAIL single_timeout: got 1, required 0"); end
        tests++;
        if (tx_err !== 0 || busy_err !== 0 || done_err !== 0 || ready_err !== 0) begin
            fails++;
            $display("FAIL single_model: tx=%0d busy=%0d done=%0d ready=%0d bad samples (first %0d), required 0",
                     tx_err, busy_err, done_err, ready_err, first_err);
        end
        // 0x55 gives an alternating line starting with the 0 start bit.
        for (int k = 0; k < 9; k++) if (got_tx[k * Cpb + 1] !== 1'(k % 2)) pat_err++;
        tests++;
        if (pat_err !== 0) begin fails++; $display("FAIL single_pattern: %0d wrong bits, required 0", pat_err); end
        foreach (got_busy[i]) if (got_busy[i] === 1'b1) busy_cnt++;
        tests++;
        if (busy_cnt !== int'(FrameLen)) begin
            fails++;
            $display("FAIL single_busy_len: got %0d cycles, required %0d", busy_cnt, FrameLen);
        end
        tests++;
        if (done_at.size() !== 1 || done_at[0] !== int'(FrameLen)) begin
            fails++;
            $display("FAIL single_done: got %0d pulses (first at %0d), required 1 at %0d",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, FrameLen);
        end
    endtask

    task automatic test_back_to_back();
        stim_q = '{8'hA5, 8'h3C};
        gap_q = '{0, 2 * Cpb};
        gap_max = 0;
        run_traffic(4);
        tests++;
        if (timed_out !== 1'b0 || tx_err !== 0 || ready_err !== 0 || done_err !== 0) begin
            fails++;
            $display("FAIL b2b_model: timeout=%0b tx=%0d ready=%0d done=%0d bad (first %0d), required 0",
                     timed_out, tx_err, ready_err, done_err, first_err);
        end
        tests++;
        if (got_ready[FrameLen - 1] !== 1'b0 || got_ready[FrameLen] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: at stop end %b, after %b, required 0 then 1",
                     got_ready[FrameLen - 1], got_ready[FrameLen]);
        end
        tests++;
        if (got_tx[FrameLen] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_gap: line %b after first stop, required 0", got_tx[FrameLen]);
        end
        tests++;
        if (done_at.size() !== 2 || done_at[0] !== int'(FrameLen) || done_at[1] !== int'(2 * FrameLen)) begin
            fails++;
            $display("FAIL b2b_done: got %0d pulses, required 2 at %0d and %0d",
                     done_at.size(), FrameLen, 2 * FrameLen);
        end
        tests++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C || rx_bad !== 0) begin
            fails++;
            $display("FAIL b2b_rx: got %0d bytes (bad %0d), required A5 3C", rx_q.size(), rx_bad);
        end
    endtask

    task automatic test_hold_valid();
        stim_q = '{8'h01, 8'h02, 8'h03};
        gap_q = '{0, 0, 0};
        gap_max = 0;
        run_traffic(4);
        tests++;
        if (timed_out !== 1'b0 || tx_err !== 0 || ready_err !== 0 || busy_err !== 0) begin
            fails++;
            $display("FAIL hold_model: timeout=%0b tx=%0d ready=%0d busy=%0d bad (first %0d), required 0",
                     timed_out, tx_err, ready_err, busy_err, first_err);
        end
        tests++;
        if (rx_q.size() !== 3 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02 || rx_q[2] !== 8'h03) begin
            fails++;
            $display("FAIL hold_rx: got %0d bytes, required 01 02 03", rx_q.size());
        end
        tests++;
        if (done_at.size() !== 3 || done_at[2] !== int'(3 * FrameLen)) begin
            fails++;
            $display("FAIL hold_done: got %0d pulses, required 3 ending at %0d", done_at.size(), 3 * FrameLen);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int         ghost;
        for (int r = 0; r < 2; r++) begin
            b = (r == 0) ? 8'hFF : (8'($urandom) & 8'hF7);
            i_valid = 1'b1;
            i_data = b;
            tick();
            i_data = 8'($urandom);
            tick();
            i_valid = 1'b0;
            repeat (16) tick();
            tests++;
            if (o_tx !== b[3]) begin
                fails++;
                $display("FAIL rst_mid_pre: bit3 of %h got %b, required %b", b, o_tx, b[3]);
            end
            i_rst = 1'b1;
            #1;
            tests++;
            if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid_async: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                         o_tx, o_ready, o_busy, o_done);
            end
            tick();
            i_rst = 1'b0;
            ghost = 0;
            repeat (2 * FrameLen) begin
                tick();
                if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) ghost++;
            end
            tests++;
            if (ghost !== 0) begin
                fails++;
                $display("FAIL rst_mid_discard: %0d active cycles after reset, required 0", ghost);
            end
        end
        stim_q = '{8'h00};
        gap_q = '{0};
        gap_max = 0;
        run_traffic(2);
        tests++;
        if (timed_out !== 1'b0 || tx_err !== 0 || rx_q.size() !== 1 || rx_q[0] !== 8'h00 ||
            done_at.size() !== 1 || done_at[0] !== int'(FrameLen)) begin
            fails++;
            $display("FAIL rst_mid_clean: tx_err=%0d rx=%0d done=%0d, required 0 1 1",
                     tx_err, rx_q.size(), done_at.size());
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        stim_q = '{8'h07, 8'h03};
        gap_q = '{0, 0};
        gap_max = 0;
        run_traffic(2);
        tests++;
        if (got_tx[9 * Cpb + Cpb / 2] !== 1'b1) begin
            fails++;
            $display("FAIL parity_07: got %b, required 1", got_tx[9 * Cpb + Cpb / 2]);
        end
        tests++;
        if (got_tx[FrameLen + 9 * Cpb + Cpb / 2] !== 1'b0) begin
            fails++;
            $display("FAIL parity_03: got %b, required 0", got_tx[FrameLen + 9 * Cpb + Cpb / 2]);
        end
        tests++;
        if (done_at.size() !== 2 || done_at[1] !== 88) begin
            fails++;
            $display("FAIL parity_len: got %0d pulses, required 2 with the second at 88", done_at.size());
        end
    endtask
`endif

    task automatic test_loopback();
        stim_q = '{8'hC3};
        gap_q = '{0};
        gap_max = 0;
        run_traffic(4);
        tests++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'hC3 || rx_bad !== 0) begin
            fails++;
            $display("FAIL loopback: got %0d bytes (first %h, bad %0d), required C3",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, rx_bad);
        end
    endtask

    task automatic test_random();
        int rx_err = 0;
        stim_q.delete();
        gap_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
        gap_max = FrameLen + 3;
        run_traffic(FrameLen);
        tests++;
        if (timed_out !== 1'b0) begin fails++; $display("FAIL random_timeout: got 1, required 0"); end
        tests++;
        if (tx_err !== 0 || busy_err !== 0 || done_err !== 0 || ready_err !== 0) begin
            fails++;
            $display("FAIL random_model: tx=%0d busy=%0d done=%0d ready=%0d bad (first %0d), required 0",
                     tx_err, busy_err, done_err, ready_err, first_err);
        end
        if (rx_q.size() != stim_q.size()) rx_err = -1;
        else foreach (stim_q[i]) if (rx_q[i] !== stim_q[i]) rx_err++;
        tests++;
        if (rx_err !== 0 || rx_bad !== 0) begin
            fails++;
            $display("FAIL random_rx: %0d bytes, %0d wrong, %0d bad frames, required %0d bytes 0 0",
                     rx_q.size(), rx_err, rx_bad, stim_q.size());
        end
        tests++;
        if (done_at.size() !== stim_q.size()) begin
            fails++;
            $display("FAIL random_done: got %0d pulses, required %0d", done_at.size(), stim_q.size());
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_data = 8'h00;
        gap_max = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_hold_valid();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_loopback();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
